transmitter_uart: RTL and testbench
===================================

TRANSMITTER_UART -- requirements
Module: transmitter

Interface
REQ-001 Parameter FREQUENCY, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter SPEED, default 9600, baud rate in bit/s; DIV = FREQUENCY/SPEED (integer division) clocks per bit.
REQ-003 CLK_i  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-high (despite the name).
REQ-005 data  input  8  byte to transmit; sampled per REQ-010.
REQ-006 dataReady  input  1  request strobe from the host.
REQ-007 tx  output  1  serial line; idle high.
REQ-008 rts  output  1  ready-to-send; 1 = idle and accepting, 0 = busy.

Function
REQ-009 States: IDLE, ARMED, START, DATA, STOP (plus PARITY when TX_PARITY_EN is defined).
REQ-010 IDLE: dataReady sampled 1 -> ARMED next cycle; rts=0 from that cycle.
- ARMED: first cycle dataReady sampled 0 -> data latched into shift register, go to START.
- dataReady stays 1 -> remain in ARMED.
REQ-011 START: tx=0 for exactly DIV clocks.
REQ-012 DATA: 8 bits LSB first, each held DIV clocks.
REQ-013 STOP: tx=1 for DIV clocks, then IDLE with rts=1 in the same cycle.
REQ-014 Frame length is 10*DIV clocks (11*DIV with parity), measured from the first start-bit clock to the return to IDLE.
REQ-015 tx and rts are registered outputs (no combinational path from inputs).
REQ-016 data changes after the latch cycle do not affect the frame in flight.
REQ-017 dataReady while in START/DATA/STOP/PARITY is ignored and not remembered; a new request needs dataReady high again while in IDLE.
REQ-018 Bit counter wraps only via the state transition; the bit timer reloads at every bit boundary; no fractional-baud accumulation.
REQ-019 DIV < 1 is illegal; elaboration fails with an error.

Reset
REQ-020 reset_n=1 forces, immediately and asynchronously: state IDLE, tx=1, rts=1, bit timer=0, bit counter=0, shift register=0.
REQ-021 Reset mid-frame aborts the frame; tx stays high; after release the block is idle and accepts a new request.

Configuration
REQ-022 Macro TX_PARITY_EN:
- Defined: a PARITY state after DATA sends the even-parity bit (XOR of the 8 data bits) for DIV clocks; frame is 11 bits.
- Undefined: no parity state; frame is 10 bits (start, 8 data, stop).

Verification (FREQUENCY=100, SPEED=10, DIV=10)
REQ-023 Assert reset_n, then release -> tx=1, rts=1; no activity for 100 clocks.
REQ-024 data=0xA5, dataReady high 3 clocks then low:
- rts=0 the cycle after dataReady first sampled high.
- tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 10 clocks.
- rts=1 exactly 100 clocks after the start bit begins.
REQ-025 data changed to 0xFF during bit 2 of a 0x00 frame -> all 8 data bits still transmit 0.
REQ-026 dataReady pulsed during the DATA state -> ignored; after the stop bit rts=1 and tx stays high.
REQ-027 reset_n pulsed during bit 4 -> tx=1 and rts=1 asynchronously; a following request for 0x3C transmits correctly.
REQ-028 With TX_PARITY_EN, data=0x07 -> parity bit 1, stop bit follows, frame 110 clocks.
- Without TX_PARITY_EN -> frame is 100 clocks.

Source files
------------

// File: rtl/transmitter_uart.sv
// transmitter_uart: UART transmitter, 8N1 framing with an rts busy handshake.
// Define TX_PARITY_EN to insert an even-parity bit after the data (8E1).
module transmitter_uart #(
    parameter int FREQUENCY = 50_000_000,
    parameter int SPEED     = 9600
) (
    input  logic       CLK_i,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       dataReady,
    output logic       tx,
    output logic       rts
);

    localparam int DIV = FREQUENCY / SPEED;
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_div_check
            $error("transmitter_uart: FREQUENCY/SPEED must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
`ifdef TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

`ifdef TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [2:0]    bit_cnt, cnt_d;
    logic [7:0]    shift, shift_d;
    logic          tx_d, rts_d;
    logic          busy, bit_done, latch;
`ifdef TX_PARITY_EN
    logic          par;
`endif

    assign busy     = (state != IDLE) && (state != ARMED);
    assign bit_done = (timer == LAST);
    assign latch    = (state == ARMED) && !dataReady;

    always_ff @(posedge CLK_i or posedge reset_n) begin
        if (reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (dataReady) state_d = ARMED;
            ARMED:   if (!dataReady) state_d = START;
            START:   if (bit_done) state_d = DATA;
            DATA:    if (bit_done && bit_cnt == 3'd7) state_d = AFTER_DATA;
`ifdef TX_PARITY_EN
            PARITY:  if (bit_done) state_d = STOP;
`endif
            STOP:    if (bit_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so tx/rts can be registered
    // without a cycle of lag behind the state register.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef TX_PARITY_EN
            PARITY:  tx_d = par;
`endif
            default: tx_d = 1'b1;
        endcase
        rts_d = (state_d == IDLE);
    end

    always_comb begin
        timer_d = (busy && !bit_done) ? timer + 1'b1 : '0;
        cnt_d   = bit_cnt;
        shift_d = shift;
        if (state == DATA && bit_done) begin
            cnt_d   = bit_cnt + 3'd1;
            shift_d = {1'b0, shift[7:1]};
        end
        if (latch) begin
            shift_d = data;
        end
    end

    always_ff @(posedge CLK_i or posedge reset_n) begin
        if (reset_n) begin
            timer   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            rts     <= 1'b1;
        end else begin
            timer   <= timer_d;
            bit_cnt <= cnt_d;
            shift   <= shift_d;
            tx      <= tx_d;
            rts     <= rts_d;
        end
    end

`ifdef TX_PARITY_EN
    always_ff @(posedge CLK_i or posedge reset_n) begin
        if (reset_n) begin
            par <= 1'b0;
        end else if (latch) begin
            par <= ^data;
        end
    end
`endif

endmodule

// File: tb/tb_transmitter_uart.sv
// tb_transmitter_uart: directed frames, scoreboard queue plus tx line monitor.
// Build with +define+TX_PARITY_EN to exercise the parity variant.
module tb_transmitter_uart;

    localparam int DIV = 10;
`ifdef TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] F_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] F_00 = 11'b1_0_00000000_0;
    localparam logic [10:0] F_5A = 11'b1_0_01011010_0;
    localparam logic [10:0] F_81 = 11'b1_0_10000001_0;
    localparam logic [10:0] F_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] F_07 = 11'b1_1_00000111_0;
`else
    localparam int NB = 10;
    localparam logic [10:0] F_A5 = 11'b1_1_10100101_0;
    localparam logic [10:0] F_00 = 11'b1_1_00000000_0;
    localparam logic [10:0] F_5A = 11'b1_1_01011010_0;
    localparam logic [10:0] F_81 = 11'b1_1_10000001_0;
    localparam logic [10:0] F_3C = 11'b1_1_00111100_0;
    localparam logic [10:0] F_07 = 11'b1_1_00000111_0;
`endif

    typedef struct {
        logic [10:0] bits;
        bit          ab;
    } exp_t;

    logic       CLK_i = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dataReady = 1'b0;
    logic       tx;
    logic       rts;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 CLK_i = ~CLK_i;

    transmitter_uart #(
        .FREQUENCY(100),
        .SPEED    (10)
    ) dut (
        .CLK_i    (CLK_i),
        .reset_n  (reset_n),
        .data     (data),
        .dataReady(dataReady),
        .tx       (tx),
        .rts      (rts)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [10:0] f,
                        input bit ab);
        data = d;
        sb.push_back('{bits: f, ab: ab});
        @(negedge CLK_i);
        dataReady = 1'b1;
        @(negedge CLK_i);
        dataReady = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int c = 0;
        while (rts !== 1'b1 && c < 300) begin
            @(negedge CLK_i);
            c++;
        end
        chk(nm, 32'(c < 300), 32'd1);
        repeat (5) @(negedge CLK_i);
    endtask

    // Monitor: a low tx outside reset marks a start bit; each frame bit
    // must hold its expected level for every one of its DIV clocks.
    initial begin : monitor
        exp_t e;
        bit   okb;
        bit   okr;
        bit   aborted;
        forever begin
            @(negedge CLK_i);
            if (!reset_n && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("spurious_frame", 32'd1, 32'd0);
                    repeat (NB * DIV) @(negedge CLK_i);
                end else begin
                    e = sb.pop_front();
                    aborted = 1'b0;
                    okr = 1'b1;
                    for (int b = 0; b < NB && !aborted; b++) begin
                        okb = 1'b1;
                        for (int k = 0; k < DIV; k++) begin
                            if (b != 0 || k != 0) @(negedge CLK_i);
                            if (reset_n) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (tx !== e.bits[b]) okb = 1'b0;
                            if (rts !== 1'b0) okr = 1'b0;
                        end
                        if (!aborted)
                            chk($sformatf("frame_bit%0d", b), 32'(okb), 32'd1);
                    end
                    chk("abort_match", 32'(aborted), 32'(e.ab));
                    if (!aborted) begin
                        chk("rts_busy_in_frame", 32'(okr), 32'd1);
                        @(negedge CLK_i);
                        chk("idle_after_stop", 32'({tx, rts}), 32'b11);
                    end
                end
            end
        end
    end

    initial begin : stim
        bit ok;
        int c;
        #1 reset_n = 1'b1;
        #1 chk("reset_state", 32'({tx, rts}), 32'b11);
        repeat (3) @(negedge CLK_i);
        reset_n = 1'b0;
        ok = 1'b1;
        repeat (100) begin
            @(negedge CLK_i);
            if ({tx, rts} !== 2'b11) ok = 1'b0;
        end
        chk("idle_100", 32'(ok), 32'd1);

        // 0xA5 with dataReady held for three clocks
        data = 8'hA5;
        sb.push_back('{bits: F_A5, ab: 1'b0});
        @(negedge CLK_i);
        chk("rts_before_req", 32'(rts), 32'd1);
        dataReady = 1'b1;
        @(posedge CLK_i);
        #1 chk("rts_drop", 32'(rts), 32'd0);
        chk("tx_armed_high", 32'(tx), 32'd1);
        repeat (3) @(negedge CLK_i);
        dataReady = 1'b0;
        wait_idle("timeout_a5");

        // 0x00 frame, data bus flips to 0xFF during data bit 2
        send(8'h00, F_00, 1'b0);
        repeat (25) @(negedge CLK_i);
        data = 8'hFF;
        wait_idle("timeout_00");

        // dataReady pulse inside DATA must be dropped
        send(8'h5A, F_5A, 1'b0);
        repeat (40) @(negedge CLK_i);
        dataReady = 1'b1;
        repeat (2) @(negedge CLK_i);
        dataReady = 1'b0;
        wait_idle("timeout_5a");
        ok = 1'b1;
        repeat (60) begin
            @(negedge CLK_i);
            if ({tx, rts} !== 2'b11) ok = 1'b0;
        end
        chk("no_retrigger", 32'(ok), 32'd1);

        // reset during data bit 3 (tx low), then a clean 0x3C
        send(8'h81, F_81, 1'b1);
        repeat (45) @(negedge CLK_i);
        chk("tx_low_before_rst", 32'(tx), 32'd0);
        reset_n = 1'b1;
        #1 chk("async_reset", 32'({tx, rts}), 32'b11);
        repeat (2) @(negedge CLK_i);
        reset_n = 1'b0;
        @(negedge CLK_i);
        chk("post_reset_idle", 32'({tx, rts}), 32'b11);
        send(8'h3C, F_3C, 1'b0);
        wait_idle("timeout_3c");

        // 0x07: frame length from start bit to rts high
        send(8'h07, F_07, 1'b0);
        c = 0;
        do begin
            @(negedge CLK_i);
            c++;
        end while (rts !== 1'b1 && c < 500);
        chk("frame_len", 32'(c), 32'(NB * DIV + 1));
        repeat (20) @(negedge CLK_i);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
